// File: rtl/oric_mem_pkg.sv
// oric_mem_pkg: FSM states, SDRAM byte-lane codes, protection base and lane-select helper
package oric_mem_pkg;
  typedef enum logic [1:0] {IDLE, CPU_WAIT, LD_WAIT, RESET_DRAIN} state_e;
  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;
  localparam logic [15:0] PROT_BASE_DEF = 16'hC000;
  function automatic logic [1:0] lane_sel(input logic we, input logic a0);
    return we ? (a0 ? DS_HI : DS_LO) : DS_BOTH;
  endfunction
endpackage

// File: rtl/oric_cpu_strobe_detect.sv
// oric_cpu_strobe_detect: CPU level strobes/address in -> one-cycle start_o, prot_rd_o and latched slot (we/ad/d) out
module oric_cpu_strobe_detect
  import oric_mem_pkg::*;
#(
  parameter int AW = 16,
  parameter logic [AW-1:0] PROT_BASE = AW'(PROT_BASE_DEF)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs_i,
  input  logic          oe_i,
  input  logic          we_i,
  input  logic [AW-1:0] ad_i,
  input  logic [7:0]    d_i,
  output logic          start_o,
  output logic          prot_rd_o,
  output logic          slot_we_o,
  output logic [AW-1:0] slot_ad_o,
  output logic [7:0]    slot_d_o
);
  logic rd, wr, rd_q, wr_q, rd_start, wr_start, hit, prot;
  logic [AW-1:0] ad_q;
  assign rd = cs_i & oe_i;
  assign wr = cs_i & we_i;
  assign rd_start = rd & (~rd_q | (ad_i != ad_q));
  assign wr_start = wr & ~wr_q;
  assign hit = ~rst_i & (rd_start | wr_start);
  assign prot = ad_i >= PROT_BASE;
  assign start_o = hit & ~prot;
  assign prot_rd_o = hit & prot & ~wr_start;
  always_ff @(posedge clk_i) begin
    rd_q <= rd;
    wr_q <= wr;
    ad_q <= ad_i;
    if (rst_i) begin
      slot_we_o <= 1'b0;
      slot_ad_o <= '0;
      slot_d_o <= '0;
    end else if (start_o) begin
      slot_we_o <= wr_start;
      slot_ad_o <= ad_i;
      slot_d_o <= d_i;
    end
  end
endmodule

// File: rtl/oric_ram_arbiter.sv
// oric_ram_arbiter: shares SDRAM port1 (sd_* toggle req/ack) between CPU ram bus (cpu_*) and ioctl loader (ld_*), CPU first
module oric_ram_arbiter
  import oric_mem_pkg::*;
#(
  parameter int AW = 16,
  parameter logic [AW-1:0] PROT_BASE = AW'(PROT_BASE_DEF),
  parameter logic [7:0] LD_INDEX = 8'd0
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_oe,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_ad,
  input  logic [7:0]    cpu_d,
  output logic [7:0]    cpu_q,
  input  logic          ld_download,
  input  logic [7:0]    ld_index,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_busy,
  output logic          sd_req,
  input  logic          sd_ack,
  output logic          sd_we,
  output logic [AW-1:0] sd_a,
  output logic [1:0]    sd_ds,
  output logic [15:0]   sd_d,
  input  logic [7:0]    sd_q
);
  state_e state_q, state_d;
  logic cpu_pend_q, cpu_pend_d, ld_busy_q, ld_busy_d, req_q, we_q;
  logic [AW-1:0] a_q, ld_a_q, iss_a;
  logic [1:0] ds_q;
  logic [15:0] d_q;
  logic [7:0] ld_d_q, cpu_q_q, iss_d;
  logic cpu_start, prot_rd, slot_we, iss_we;
  logic [AW-1:0] slot_ad;
  logic [7:0] slot_d;
  logic done, outstanding, capture, issue_cpu, issue_ld, cpu_rd_done, ld_done;

  oric_cpu_strobe_detect #(.AW(AW), .PROT_BASE(PROT_BASE)) u_det (
    .clk_i(clk_sys),
    .rst_i(reset),
    .cs_i(cpu_cs),
    .oe_i(cpu_oe),
    .we_i(cpu_we),
    .ad_i(cpu_ad),
    .d_i(cpu_d),
    .start_o(cpu_start),
    .prot_rd_o(prot_rd),
    .slot_we_o(slot_we),
    .slot_ad_o(slot_ad),
    .slot_d_o(slot_d)
  );

  assign done = sd_ack == req_q;
  assign outstanding = (state_q != IDLE) & ~done;
  assign capture = ld_wr & ld_download & (ld_index == LD_INDEX) & ~ld_busy_q;
  assign cpu_pend_d = cpu_start | (cpu_pend_q & ~issue_cpu);
  assign ld_busy_d = capture | (ld_busy_q & ~ld_done);
  assign iss_we = issue_cpu ? slot_we : 1'b1;
  assign iss_a = issue_cpu ? slot_ad : ld_a_q;
  assign iss_d = issue_cpu ? slot_d : ld_d_q;

  always_comb begin
    state_d = state_q;
    issue_cpu = 1'b0;
    issue_ld = 1'b0;
    cpu_rd_done = 1'b0;
    ld_done = 1'b0;
    case (state_q)
      IDLE: begin
        issue_cpu = cpu_pend_q;
        issue_ld = ~cpu_pend_q & ld_busy_q;
        state_d = cpu_pend_q ? CPU_WAIT : ld_busy_q ? LD_WAIT : IDLE;
      end
      CPU_WAIT: begin
        cpu_rd_done = done & ~we_q;
        state_d = done ? IDLE : CPU_WAIT;
      end
      LD_WAIT: begin
        ld_done = done;
        state_d = done ? IDLE : LD_WAIT;
      end
      default: state_d = done ? IDLE : RESET_DRAIN;
    endcase
  end

  // An access still in flight at reset keeps req and its issue lines untouched and is drained;
  // otherwise req aligns to ack so the port sees no new request.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= outstanding ? RESET_DRAIN : IDLE;
      cpu_pend_q <= 1'b0;
      ld_busy_q <= 1'b0;
      cpu_q_q <= '0;
      if (!outstanding) begin
        req_q <= sd_ack;
        we_q <= 1'b0;
        a_q <= '0;
        ds_q <= DS_BOTH;
        d_q <= '0;
      end
    end else begin
      state_q <= state_d;
      cpu_pend_q <= cpu_pend_d;
      ld_busy_q <= ld_busy_d;
      if (capture) begin
        ld_a_q <= ld_addr;
        ld_d_q <= ld_data;
      end
      if (issue_cpu | issue_ld) begin
        req_q <= ~req_q;
        we_q <= iss_we;
        a_q <= iss_a;
        ds_q <= lane_sel(iss_we, iss_a[0]);
        d_q <= {iss_d, iss_d};
      end
      cpu_q_q <= prot_rd ? 8'h00 : cpu_rd_done ? sd_q : cpu_q_q;
    end
  end

  assign cpu_q = cpu_q_q;
  assign ld_busy = ld_busy_q;
  assign sd_req = req_q;
  assign sd_we = we_q;
  assign sd_a = a_q;
  assign sd_ds = ds_q;
  assign sd_d = d_q;
endmodule

// File: tb/tb_oric_ram_arbiter.sv
// tb_oric_ram_arbiter: directed scoreboard bench with a 4-cycle toggle-ack SDRAM model
module tb_oric_ram_arbiter;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_ad = '0;
  logic [7:0] cpu_d = '0;
  logic [7:0] cpu_q;
  logic ld_download = 1'b0, ld_wr = 1'b0;
  logic [7:0] ld_index = '0, ld_data = '0;
  logic [15:0] ld_addr = '0;
  logic ld_busy;
  logic sd_req, sd_we;
  logic sd_ack = 1'b0;
  logic [15:0] sd_a, sd_d;
  logic [1:0] sd_ds;
  logic [7:0] sd_q = '0;

  typedef struct {
    logic we;
    logic [15:0] a;
    logic [1:0] ds;
    logic [15:0] d;
    int at;
  } acc_t;
  acc_t exp_q[$];
  acc_t mon_e;
  logic [34:0] cur = '0;
  logic last_req = 1'b0;
  logic hold = 1'b0;
  int checks = 0, errors = 0, cyc_n = 0, toggles = 0, ack_cnt = 0;
  int base, t0;

  oric_ram_arbiter dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .cpu_cs(cpu_cs),
    .cpu_oe(cpu_oe),
    .cpu_we(cpu_we),
    .cpu_ad(cpu_ad),
    .cpu_d(cpu_d),
    .cpu_q(cpu_q),
    .ld_download(ld_download),
    .ld_index(ld_index),
    .ld_wr(ld_wr),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_busy(ld_busy),
    .sd_req(sd_req),
    .sd_ack(sd_ack),
    .sd_we(sd_we),
    .sd_a(sd_a),
    .sd_ds(sd_ds),
    .sd_d(sd_d),
    .sd_q(sd_q)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc_n <= cyc_n + 1;

  always @(posedge clk_sys) begin
    if (sd_req != sd_ack) begin
      if (ack_cnt >= 3 && !hold) begin
        sd_ack <= sd_req;
        ack_cnt <= 0;
      end else ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic push(input logic we, input logic [15:0] a, input logic [1:0] ds, input logic [15:0] d, input int at);
    acc_t e;
    e.we = we;
    e.a = a;
    e.ds = ds;
    e.d = d;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic summary;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  always @(negedge clk_sys) begin
    if (sd_req != last_req) begin
      last_req = sd_req;
      toggles++;
      cur = {sd_we, sd_a, sd_ds, sd_d};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_toggle: got access we=%b a=%h ds=%b d=%h, expected no access", sd_we, sd_a, sd_ds, sd_d);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_we", 64'(sd_we), 64'(mon_e.we));
        check("issue_a", 64'(sd_a), 64'(mon_e.a));
        check("issue_ds", 64'(sd_ds), 64'(mon_e.ds));
        check("issue_d", 64'(sd_d), 64'(mon_e.d));
        if (mon_e.at >= 0) check("issue_cycle", 64'(cyc_n), 64'(mon_e.at));
      end
    end else if (sd_req != sd_ack) check("issue_stable", 64'({sd_we, sd_a, sd_ds, sd_d}), 64'(cur));
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    summary();
    $fatal(1);
  end

  initial begin
    cyc(3);
    check("rst_cpu_q", 64'(cpu_q), 64'h0);
    check("rst_ld_busy", 64'(ld_busy), 64'h0);
    check("rst_sd_req", 64'(sd_req), 64'h0);
    check("rst_sd_we", 64'(sd_we), 64'h0);
    check("rst_sd_a", 64'(sd_a), 64'h0);
    check("rst_sd_ds", 64'(sd_ds), 64'h3);
    check("rst_sd_d", 64'(sd_d), 64'h0);
    reset = 1'b0;
    cyc(2);
    // CPU read, idle port
    base = cyc_n;
    cpu_ad = 16'h0400;
    cpu_d = 8'h00;
    cpu_cs = 1'b1;
    cpu_oe = 1'b1;
    sd_q = 8'h5A;
    push(1'b0, 16'h0400, 2'b11, 16'h0000, base + 2);
    cyc(8);
    check("rd_cpu_q", 64'(cpu_q), 64'h5A);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    cyc(2);
    // CPU write, odd byte, strobe held long
    base = cyc_n;
    t0 = toggles;
    cpu_ad = 16'h0401;
    cpu_d = 8'h3C;
    cpu_cs = 1'b1;
    cpu_we = 1'b1;
    push(1'b1, 16'h0401, 2'b10, 16'h3C3C, base + 2);
    cyc(10);
    check("wr_one_toggle", 64'(toggles - t0), 64'd1);
    check("wr_cpu_q_hold", 64'(cpu_q), 64'h5A);
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    cyc(2);
    // protected write then protected read
    t0 = toggles;
    cpu_ad = 16'hC123;
    cpu_d = 8'h77;
    cpu_cs = 1'b1;
    cpu_we = 1'b1;
    cyc(6);
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    cyc(2);
    check("prot_wr_cpu_q", 64'(cpu_q), 64'h5A);
    cpu_ad = 16'hFFFC;
    cpu_cs = 1'b1;
    cpu_oe = 1'b1;
    cyc(1);
    check("prot_rd_cpu_q", 64'(cpu_q), 64'h0);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    cyc(4);
    check("prot_no_toggle", 64'(toggles - t0), 64'd0);
    // loader write during an in-flight CPU read
    ld_download = 1'b1;
    ld_index = 8'd0;
    base = cyc_n;
    cpu_ad = 16'h0200;
    cpu_d = 8'h00;
    cpu_cs = 1'b1;
    cpu_oe = 1'b1;
    sd_q = 8'h77;
    push(1'b0, 16'h0200, 2'b11, 16'h0000, base + 2);
    cyc(3);
    ld_addr = 16'hC000;
    ld_data = 8'hA9;
    ld_wr = 1'b1;
    push(1'b1, 16'hC000, 2'b01, 16'hA9A9, base + 8);
    cyc(1);
    ld_wr = 1'b0;
    check("ld_busy_set", 64'(ld_busy), 64'h1);
    cyc(1);
    ld_addr = 16'h1234;
    ld_data = 8'h55;
    ld_wr = 1'b1;
    cyc(1);
    ld_wr = 1'b0;
    cyc(6);
    check("ld_busy_before_ack", 64'(ld_busy), 64'h1);
    cyc(1);
    check("ld_busy_clear", 64'(ld_busy), 64'h0);
    check("ld_cpu_q", 64'(cpu_q), 64'h77);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    cyc(2);
    // CPU detect and loader capture in the same idle cycle
    base = cyc_n;
    t0 = toggles;
    cpu_ad = 16'h0010;
    cpu_d = 8'h11;
    cpu_cs = 1'b1;
    cpu_we = 1'b1;
    ld_addr = 16'h0123;
    ld_data = 8'h42;
    ld_wr = 1'b1;
    push(1'b1, 16'h0010, 2'b01, 16'h1111, base + 2);
    push(1'b1, 16'h0123, 2'b10, 16'h4242, base + 8);
    cyc(1);
    ld_wr = 1'b0;
    cyc(13);
    check("both_two_toggles", 64'(toggles - t0), 64'd2);
    check("both_ld_busy", 64'(ld_busy), 64'h0);
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    cyc(2);
    // reset while a loader write is outstanding
    hold = 1'b1;
    base = cyc_n;
    ld_addr = 16'h0050;
    ld_data = 8'h99;
    ld_wr = 1'b1;
    push(1'b1, 16'h0050, 2'b01, 16'h9999, base + 2);
    cyc(1);
    ld_wr = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(3);
    check("drain_ld_busy", 64'(ld_busy), 64'h0);
    check("drain_cpu_q", 64'(cpu_q), 64'h0);
    reset = 1'b0;
    t0 = toggles;
    cpu_ad = 16'h0300;
    cpu_d = 8'h00;
    cpu_cs = 1'b1;
    cpu_oe = 1'b1;
    sd_q = 8'hC3;
    cyc(5);
    check("drain_no_toggle", 64'(toggles - t0), 64'd0);
    hold = 1'b0;
    push(1'b0, 16'h0300, 2'b11, 16'h0000, cyc_n + 3);
    cyc(8);
    check("drain_rd_cpu_q", 64'(cpu_q), 64'hC3);
    check("drain_one_toggle", 64'(toggles - t0), 64'd1);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    cyc(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    summary();
    $finish;
  end
endmodule
